// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, FSM states and
// instruction-word field helpers.
package ucode_pkg;

  localparam logic [2:0] OP_WAIT  = 3'b000;
  localparam logic [2:0] OP_JUMP  = 3'b001;
  localparam logic [2:0] OP_DJNZ  = 3'b010;
  localparam logic [2:0] OP_LDCNT = 3'b011;
  localparam logic [2:0] OP_HALT  = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Word layout, MSB->LSB: {pwm[N-1]..pwm[0], vec, opcode, arg}
  function automatic int instr_width(input int addr_w, input int out_w,
                                     input int pwm_ch, input int pwm_w);
    return pwm_ch * pwm_w + out_w + 3 + addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int vec_lsb(input int addr_w);
    return addr_w + 3;
  endfunction

  function automatic int pwm_lsb(input int addr_w, input int out_w);
    return addr_w + 3 + out_w;
  endfunction

endpackage

// File: rtl/ucode_prescaler.sv
// Wait-timer prescaler: counts 0..PRESCALE-1 while enabled and pulses o_tick
// on the cycle it wraps. Synchronous clear restarts the count at zero.
module ucode_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer driving LED vector and PWM duties from a synchronous ROM.
// Define UCODE_CALL_EN to enable single-level CALL/RET; otherwise they act as NOP.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int OUT_W    = 12,
  parameter int PWM_CH   = 2,
  parameter int PWM_W    = 4,
  parameter int PRESCALE = 1000,
  localparam int INSTR_W = instr_width(ADDR_W, OUT_W, PWM_CH, PWM_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [INSTR_W-1:0]       rom_data,
  output logic [OUT_W-1:0]         vec,
  output logic [PWM_CH*PWM_W-1:0]  pwm,
  output logic [ADDR_W-1:0]        pc,
  output logic                     halted
);

  localparam int OP_LSB  = op_lsb(ADDR_W);
  localparam int VEC_LSB = vec_lsb(ADDR_W);
  localparam int PWM_LSB = pwm_lsb(ADDR_W, OUT_W);
  localparam int PWM_TOT = PWM_CH * PWM_W;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [OUT_W-1:0]    r_vec;
  logic [PWM_TOT-1:0]  r_pwm;
  logic [ADDR_W-1:0]   r_loop_cnt;
  logic [ADDR_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0]   r_arg;
`ifdef UCODE_CALL_EN
  logic [ADDR_W-1:0]   r_ret_addr;
  logic [ADDR_W-1:0]   w_ret_next;
`endif

  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [OUT_W-1:0]    w_vec_next;
  logic [PWM_TOT-1:0]  w_pwm_next;
  logic [ADDR_W-1:0]   w_loop_next;
  logic [ADDR_W-1:0]   w_wait_next;
  logic [ADDR_W-1:0]   w_arg_next;
  logic                w_presc_clr;
  logic                w_presc_en;
  logic                w_tick;

  logic [2:0]          w_op;
  logic [ADDR_W-1:0]   w_arg;
  logic [OUT_W-1:0]    w_rom_vec;
  logic [PWM_TOT-1:0]  w_rom_pwm;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_loop_dec;

  assign w_op      = rom_data[OP_LSB +: 3];
  assign w_arg     = rom_data[ADDR_W-1:0];
  assign w_rom_vec = rom_data[VEC_LSB +: OUT_W];
  assign w_pc_inc  = r_pc + ONE;
  assign w_loop_dec = r_loop_cnt - ONE;

  genvar gi;
  generate
    for (gi = 0; gi < PWM_CH; gi++) begin : g_pwm_field
      assign w_rom_pwm[gi*PWM_W +: PWM_W] = rom_data[PWM_LSB + gi*PWM_W +: PWM_W];
    end
  endgenerate

  ucode_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_presc_clr),
    .i_en   (w_presc_en),
    .o_tick (w_tick)
  );

  // Gated by rst_n so the strobe is low for the whole reset, whatever run does.
  assign rom_en   = rst_n && run && (r_state == FETCH);
  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign vec      = r_vec;
  assign pwm      = r_pwm;
  assign halted   = (r_state == HALT);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_vec_next   = r_vec;
    w_pwm_next   = r_pwm;
    w_loop_next  = r_loop_cnt;
    w_wait_next  = r_wait_cnt;
    w_arg_next   = r_arg;
    w_presc_clr  = 1'b0;
    w_presc_en   = 1'b0;
`ifdef UCODE_CALL_EN
    w_ret_next   = r_ret_addr;
`endif
    case (r_state)
      FETCH: begin
        if (run) w_state_next = EXEC;
      end
      EXEC: begin
        w_vec_next   = w_rom_vec;
        w_pwm_next   = w_rom_pwm;
        w_arg_next   = w_arg;
        w_state_next = FETCH;
        case (w_op)
          OP_WAIT: begin
            if (w_arg == '0) begin
              w_pc_next = w_pc_inc;
            end else begin
              w_presc_clr  = 1'b1;
              w_wait_next  = '0;
              w_state_next = WAIT;
            end
          end
          OP_JUMP:  w_pc_next = w_arg;
          OP_LDCNT: begin
            w_loop_next = w_arg;
            w_pc_next   = w_pc_inc;
          end
          OP_DJNZ: begin
            if (r_loop_cnt != '0) begin
              w_loop_next = w_loop_dec;
              w_pc_next   = (w_loop_dec != '0) ? w_arg : w_pc_inc;
            end else begin
              w_pc_next = w_pc_inc;
            end
          end
          OP_HALT:  w_state_next = HALT;
`ifdef UCODE_CALL_EN
          OP_CALL: begin
            w_ret_next = w_pc_inc;
            w_pc_next  = w_arg;
          end
          OP_RET:   w_pc_next = r_ret_addr;
`endif
          default:  w_pc_next = w_pc_inc;
        endcase
      end
      WAIT: begin
        w_presc_en = 1'b1;
        if (w_tick) begin
          w_wait_next = r_wait_cnt + ONE;
          // Last tick of the wait: arg ticks of PRESCALE cycles have elapsed.
          if (r_wait_cnt == r_arg - ONE) begin
            w_pc_next    = w_pc_inc;
            w_state_next = FETCH;
          end
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= '0;
      r_vec      <= '0;
      r_pwm      <= '0;
      r_loop_cnt <= '0;
      r_wait_cnt <= '0;
      r_arg      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_vec      <= w_vec_next;
      r_pwm      <= w_pwm_next;
      r_loop_cnt <= w_loop_next;
      r_wait_cnt <= w_wait_next;
      r_arg      <= w_arg_next;
    end
  end

`ifdef UCODE_CALL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ret_addr <= '0;
    else        r_ret_addr <= w_ret_next;
  end
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios plus random programs checked
// against an instruction-level model. Honours UCODE_CALL_EN if defined.
module tb_ucode_sequencer;

  localparam int ADDR_W   = 9;
  localparam int OUT_W    = 12;
  localparam int PWM_CH   = 2;
  localparam int PWM_W    = 4;
  localparam int PRESCALE = 4;
  localparam int INSTR_W  = 32;
  localparam int DEPTH    = 512;

  localparam int O_WAIT = 0, O_JUMP = 1, O_DJNZ = 2, O_LDCNT = 3;
  localparam int O_HALT = 4, O_CALL = 5, O_RET = 6, O_NOP = 7;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                run = 1'b0;
  logic                rom_en;
  logic [ADDR_W-1:0]   rom_addr;
  logic [INSTR_W-1:0]  rom_data;
  logic [OUT_W-1:0]    vec;
  logic [7:0]          pwm;
  logic [ADDR_W-1:0]   pc;
  logic                halted;

  logic [INSTR_W-1:0]  rom [DEPTH];
  int cyc = 0;
  int checks = 0;
  int passed = 0;

  ucode_sequencer #(
    .ADDR_W(ADDR_W), .OUT_W(OUT_W), .PWM_CH(PWM_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .vec(vec), .pwm(pwm), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks want completion", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input int v, input int p, input int op, input int arg);
    logic [31:0] w;
    w = {8'(p), 12'(v), 3'(op), 9'(arg)};
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < DEPTH; i++) rom[i] = w;
  endtask

  task automatic start(input logic r);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run   = r;
    #1;
  endtask

  task automatic wait_fetch(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rom_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    fill(mk(0, 0, O_NOP, 0));
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rom_en !== 1'b0) $display("FAIL reset_rom_en: got %b want 0", rom_en); else passed++;
    checks++; if (pc !== '0) $display("FAIL reset_pc: got %h want 0", pc); else passed++;
    checks++; if (vec !== '0) $display("FAIL reset_vec: got %h want 0", vec); else passed++;
    checks++; if (pwm !== '0) $display("FAIL reset_pwm: got %h want 0", pwm); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
  endtask

  task automatic test_first_instr();
    fill(mk(0, 0, O_NOP, 0));
    rom[0] = mk('hABC, 'h5A, O_WAIT, 0);
    rom[1] = mk('h123, 'hC3, O_HALT, 0);
    start(1'b1);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 9'd0)
      $display("FAIL first_fetch: got en=%b addr=%h want en=1 addr=0", rom_en, rom_addr);
    else passed++;
    tick();
    tick();
    checks++;
    if (vec !== 12'hABC || pwm !== 8'h5A || pc !== 9'd1)
      $display("FAIL first_exec: got vec=%h pwm=%h pc=%h want ABC 5A 1", vec, pwm, pc);
    else passed++;
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || vec !== 12'h123 || pwm !== 8'hC3)
      $display("FAIL first_halt: got halted=%b vec=%h pwm=%h want 1 123 C3", halted, vec, pwm);
    else passed++;
  endtask

  task automatic test_wait_timing();
    bit ok;
    int n;
    fill(mk(0, 0, O_NOP, 0));
    rom[1] = mk(1, 1, O_WAIT, 3);
    rom[2] = mk(2, 2, O_HALT, 0);
    start(1'b1);
    wait_fetch(8, ok);
    tick();
    wait_fetch(8, ok);
    checks++;
    if (!ok || rom_addr !== 9'd1) $display("FAIL wait_fetch1: got ok=%b addr=%h want 1 1", ok, rom_addr);
    else passed++;
    tick();
    tick();
    n = 0;
    while (pc === 9'd1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != 12) $display("FAIL wait_cycles: got %0d want 12", n); else passed++;
    checks++;
    if (pc !== 9'd2 || rom_en !== 1'b1)
      $display("FAIL wait_exit: got pc=%h en=%b want 2 1", pc, rom_en);
    else passed++;
  endtask

  task automatic test_djnz_halt();
    bit ok;
    int n;
    int exp_a[5];
    exp_a = '{0, 1, 1, 1, 2};
    fill(mk(0, 0, O_NOP, 0));
    rom[0] = mk(1, 1, O_LDCNT, 3);
    rom[1] = mk(2, 2, O_DJNZ, 1);
    rom[2] = mk(3, 3, O_HALT, 0);
    start(1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_fetch(8, ok);
      checks++;
      if (!ok || rom_addr !== 9'(exp_a[k]))
        $display("FAIL djnz_fetch%0d: got ok=%b addr=%h want %h", k, ok, rom_addr, exp_a[k]);
      else passed++;
      tick();
    end
    tick();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (halted === 1'b1 && pc === 9'd2 && rom_en === 1'b0) n++;
      tick();
    end
    checks++; if (n != 100) $display("FAIL halt_hold: got %0d cycles want 100", n); else passed++;
  endtask

  task automatic test_wrap_run();
    bit ok;
    int n;
    int exp_a[3];
    exp_a = '{0, 511, 0};
    fill(mk(0, 0, O_NOP, 0));
    rom[0]   = mk(1, 1, O_JUMP, 'h1FF);
    rom[511] = mk(7, 7, O_NOP, 0);
    start(1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_fetch(8, ok);
      checks++;
      if (!ok || rom_addr !== 9'(exp_a[k]))
        $display("FAIL wrap_fetch%0d: got ok=%b addr=%h want %h", k, ok, rom_addr, exp_a[k]);
      else passed++;
      tick();
    end
    run = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rom_en === 1'b0 && pc === 9'h1FF) n++;
    end
    checks++; if (n != 5) $display("FAIL run_stall: got %0d idle cycles want 5", n); else passed++;
    run = 1'b1;
    #1;
    wait_fetch(8, ok);
    checks++;
    if (!ok || rom_addr !== 9'h1FF) $display("FAIL run_resume: got ok=%b addr=%h want 1 1ff", ok, rom_addr);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit ok;
    fill(mk(0, 0, O_NOP, 0));
    rom[0] = mk('hFFF, 'hFF, O_NOP, 0);
    rom[1] = mk('h5A5, 'h3C, O_WAIT, 50);
    start(1'b1);
    wait_fetch(8, ok);
    tick();
    wait_fetch(8, ok);
    tick();
    repeat (5) tick();
    checks++;
    if (vec !== 12'h5A5 || pc !== 9'd1) $display("FAIL midwait_state: got vec=%h pc=%h want 5a5 1", vec, pc);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== '0 || pwm !== '0 || pc !== '0)
      $display("FAIL async_reset: got vec=%h pwm=%h pc=%h want 0 0 0", vec, pwm, pc);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    #1;
    wait_fetch(8, ok);
    checks++;
    if (!ok || rom_addr !== 9'd0) $display("FAIL restart_fetch: got ok=%b addr=%h want 1 0", ok, rom_addr);
    else passed++;
  endtask

  task automatic test_call();
    bit ok;
    int exp_a[8];
`ifdef UCODE_CALL_EN
    exp_a = '{0, 1, 2, 3, 4, 5, 20, 6};
`else
    exp_a = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    fill(mk(0, 0, O_NOP, 0));
    rom[5]  = mk(1, 2, O_CALL, 20);
    rom[20] = mk(3, 4, O_RET, 0);
    start(1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_fetch(8, ok);
      checks++;
      if (!ok || rom_addr !== 9'(exp_a[k]))
        $display("FAIL call_fetch%0d: got ok=%b addr=%h want %h", k, ok, rom_addr, exp_a[k]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_random(input int nprog);
    int m_pc, m_loop, m_ret, m_vec, m_pwm, m_dur, nxt, op, arg, last_cyc, extra, stall;
    bit m_halt, ok;
    logic [31:0] w;
    for (int p = 0; p < nprog; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        op = int'($urandom_range(0, 7));
        if (op == O_HALT && $urandom_range(0, 7) != 0) op = O_NOP;
        if (op == O_WAIT) arg = int'($urandom_range(0, 3));
        else if (op == O_LDCNT) arg = int'($urandom_range(0, 4));
        else arg = int'($urandom_range(0, DEPTH - 1));
        rom[i] = mk(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), op, arg);
      end
      m_pc = 0; m_loop = 0; m_ret = 0; m_vec = 0; m_pwm = 0;
      m_dur = 0; m_halt = 1'b0; extra = 0; last_cyc = 0;
      start(1'b1);
      for (int n = 0; n < 40 && !m_halt; n++) begin
        wait_fetch(64, ok);
        checks++;
        if (!ok || rom_addr !== 9'(m_pc) || pc !== 9'(m_pc))
          $display("FAIL rand_fetch p%0d n%0d: got ok=%b addr=%h pc=%h want %h", p, n, ok, rom_addr, pc, m_pc);
        else passed++;
        checks++;
        if (vec !== 12'(m_vec) || pwm !== 8'(m_pwm))
          $display("FAIL rand_out p%0d n%0d: got vec=%h pwm=%h want %h %h", p, n, vec, pwm, m_vec, m_pwm);
        else passed++;
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != m_dur + extra)
            $display("FAIL rand_period p%0d n%0d: got %0d cycles want %0d", p, n, cyc - last_cyc, m_dur + extra);
          else passed++;
        end
        if (!ok) break;
        last_cyc = cyc;
        w = rom[m_pc];
        op = int'(w[11:9]);
        arg = int'(w[8:0]);
        m_vec = int'(w[23:12]);
        m_pwm = int'(w[31:24]);
        m_dur = 2;
        nxt = (m_pc + 1) % DEPTH;
        case (op)
          O_WAIT: begin m_dur = 2 + arg * PRESCALE; m_pc = nxt; end
          O_JUMP: m_pc = arg;
          O_DJNZ: begin
            if (m_loop > 0) begin
              m_loop = m_loop - 1;
              m_pc = (m_loop != 0) ? arg : nxt;
            end else m_pc = nxt;
          end
          O_LDCNT: begin m_loop = arg; m_pc = nxt; end
          O_HALT: m_halt = 1'b1;
`ifdef UCODE_CALL_EN
          O_CALL: begin m_ret = nxt; m_pc = arg; end
          O_RET: m_pc = m_ret;
`endif
          default: m_pc = nxt;
        endcase
        tick();
        extra = 0;
        if (m_dur == 2 && !m_halt && $urandom_range(0, 3) == 0) begin
          stall = int'($urandom_range(2, 4));
          run = 1'b0;
          repeat (stall) tick();
          run = 1'b1;
          #1;
          extra = stall - 1;
        end
      end
      if (m_halt) begin
        tick();
        checks++;
        if (halted !== 1'b1 || vec !== 12'(m_vec) || pwm !== 8'(m_pwm))
          $display("FAIL rand_halt p%0d: got halted=%b vec=%h pwm=%h want 1 %h %h", p, halted, vec, pwm, m_vec, m_pwm);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_instr();
    test_wait_timing();
    test_djnz_halt();
    test_wrap_run();
    test_async_reset();
    test_call();
    test_random(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
